// File: rtl/qoa_quantizer.sv
// rtl/qoa_quantizer.sv - two-stage QOA residual quantizer with valid/ready handshake
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid, in_ready  input handshake for one residual/scalefactor pair
//   residual [16:0]     signed residual (sample minus prediction)
//   sf_quant [3:0]      scalefactor index 0..15
//   out_valid, out_ready output handshake for one quantized result
//   qr [2:0]            quantized residual index 0..7
//   recon [15:0]        signed dequantized value   (QOA_QUANT_RECON_EN only)
//   error [16:0]        signed residual - recon    (QOA_QUANT_RECON_EN only)
//
// Build option: define QOA_QUANT_RECON_EN to add the recon/error outputs.
module qoa_quantizer (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [16:0] residual,
    input  logic        [3:0]  sf_quant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [2:0]  qr
`ifdef QOA_QUANT_RECON_EN
    ,
    output logic signed [15:0] recon,
    output logic signed [16:0] error
`endif
);

    // Fixed-point reciprocal of each scalefactor, scaled by 2^16.
    function automatic logic [17:0] recip(input logic [3:0] s);
        case (s)
            4'd0:    recip = 18'd65536;
            4'd1:    recip = 18'd9363;
            4'd2:    recip = 18'd3121;
            4'd3:    recip = 18'd1457;
            4'd4:    recip = 18'd781;
            4'd5:    recip = 18'd475;
            4'd6:    recip = 18'd311;
            4'd7:    recip = 18'd216;
            4'd8:    recip = 18'd156;
            4'd9:    recip = 18'd117;
            4'd10:   recip = 18'd90;
            4'd11:   recip = 18'd71;
            4'd12:   recip = 18'd57;
            4'd13:   recip = 18'd47;
            4'd14:   recip = 18'd39;
            default: recip = 18'd32;
        endcase
    endfunction

    // The whole pipeline moves together; a held result blocks everything.
    logic advance;
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    // Stage 1
    logic               s1_valid_q;
    logic signed [34:0] prod_d, prod_q;
    logic               res_neg_q, res_nz_q;

    assign prod_d = $signed({{18{residual[16]}}, residual}) * $signed({17'b0, recip(sf_quant)});

    // Stage 2
    logic               out_valid_q;
    logic        [2:0]  qr_d, qr_q;
    logic signed [34:0] rounded;
    logic signed [19:0] n_raw, n_corr, s_res, s_n;
    logic signed [4:0]  n_clamp;
    logic        [4:0]  q_idx;

    always_comb begin
        rounded = prod_q + 35'sd32768;
        n_raw   = 20'(rounded >>> 16);
        s_res   = res_neg_q ? -20'sd1 : (res_nz_q ? 20'sd1 : 20'sd0);
        s_n     = n_raw[19] ? -20'sd1 : ((n_raw != 20'sd0) ? 20'sd1 : 20'sd0);
        // Nudges n away from zero so a nonzero residual never quantizes to 0
        // and the result keeps the residual's sign.
        n_corr  = n_raw + s_res - s_n;
        if (n_corr > 20'sd8)
            n_clamp = 5'sd8;
        else if (n_corr < -20'sd8)
            n_clamp = -5'sd8;
        else
            n_clamp = n_corr[4:0];
        q_idx = n_clamp[4:0] + 5'd8;
        case (q_idx)
            5'd0, 5'd1, 5'd2:    qr_d = 3'd7;
            5'd3, 5'd4:          qr_d = 3'd5;
            5'd5, 5'd6:          qr_d = 3'd3;
            5'd7:                qr_d = 3'd1;
            5'd8, 5'd9:          qr_d = 3'd0;
            5'd10, 5'd11:        qr_d = 3'd2;
            5'd12, 5'd13:        qr_d = 3'd4;
            default:             qr_d = 3'd6;
        endcase
    end

`ifdef QOA_QUANT_RECON_EN
    logic        [3:0]  sf_q;
    logic signed [16:0] residual_q;
    logic signed [15:0] recon_d, recon_q;
    logic signed [16:0] error_d, error_q;
    logic        [63:0] dq_row;
    logic        [15:0] dq_mag;

    // Dequantization magnitudes packed {col3, col2, col1, col0}.
    always_comb begin
        case (sf_q)
            4'd0:    dq_row = {16'd7,     16'd5,    16'd3,    16'd1};
            4'd1:    dq_row = {16'd49,    16'd32,   16'd18,   16'd5};
            4'd2:    dq_row = {16'd147,   16'd95,   16'd53,   16'd16};
            4'd3:    dq_row = {16'd315,   16'd203,  16'd113,  16'd34};
            4'd4:    dq_row = {16'd588,   16'd378,  16'd210,  16'd63};
            4'd5:    dq_row = {16'd966,   16'd621,  16'd345,  16'd104};
            4'd6:    dq_row = {16'd1477,  16'd950,  16'd528,  16'd158};
            4'd7:    dq_row = {16'd2128,  16'd1368, 16'd760,  16'd228};
            4'd8:    dq_row = {16'd2947,  16'd1895, 16'd1053, 16'd316};
            4'd9:    dq_row = {16'd3934,  16'd2529, 16'd1405, 16'd422};
            4'd10:   dq_row = {16'd5117,  16'd3290, 16'd1828, 16'd548};
            4'd11:   dq_row = {16'd6496,  16'd4176, 16'd2320, 16'd696};
            4'd12:   dq_row = {16'd8099,  16'd5207, 16'd2893, 16'd868};
            4'd13:   dq_row = {16'd9933,  16'd6386, 16'd3548, 16'd1064};
            4'd14:   dq_row = {16'd12005, 16'd7718, 16'd4288, 16'd1286};
            default: dq_row = {16'd14336, 16'd9216, 16'd5120, 16'd1536};
        endcase
        case (qr_d[2:1])
            2'd0:    dq_mag = dq_row[15:0];
            2'd1:    dq_mag = dq_row[31:16];
            2'd2:    dq_mag = dq_row[47:32];
            default: dq_mag = dq_row[63:48];
        endcase
        recon_d = qr_d[0] ? -$signed(dq_mag) : $signed(dq_mag);
        // Signs of residual and recon always agree, so 17 bits cannot overflow.
        error_d = residual_q - {recon_d[15], recon_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sf_q       <= '0;
            residual_q <= '0;
            recon_q    <= '0;
            error_q    <= '0;
        end else if (advance) begin
            if (in_valid) begin
                sf_q       <= sf_quant;
                residual_q <= residual;
            end
            if (s1_valid_q) begin
                recon_q <= recon_d;
                error_q <= error_d;
            end
        end
    end

    assign recon = recon_q;
    assign error = error_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            res_neg_q   <= 1'b0;
            res_nz_q    <= 1'b0;
            out_valid_q <= 1'b0;
            qr_q        <= '0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (in_valid) begin
                prod_q    <= prod_d;
                res_neg_q <= residual[16];
                res_nz_q  <= (residual != 17'sd0);
            end
            if (s1_valid_q)
                qr_q <= qr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign qr        = qr_q;

endmodule

// File: tb/tb_qoa_quantizer.sv
// tb/tb_qoa_quantizer.sv - self-checking bench for qoa_quantizer
module tb_qoa_quantizer;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [16:0] residual;
    logic        [3:0]  sf_quant;
    logic               out_valid;
    logic               out_ready;
    logic        [2:0]  qr;
`ifdef QOA_QUANT_RECON_EN
    logic signed [15:0] recon;
    logic signed [16:0] error;
`endif

    qoa_quantizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .residual  (residual),
        .sf_quant  (sf_quant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .qr        (qr)
`ifdef QOA_QUANT_RECON_EN
        ,
        .recon     (recon),
        .error     (error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int qr;
        int recon;
        int err;
    } exp_t;

    localparam int RECIP [16] = '{65536, 9363, 3121, 1457, 781, 475, 311, 216,
                                  156, 117, 90, 71, 57, 47, 39, 32};
    localparam int QTAB  [17] = '{7, 7, 7, 5, 5, 3, 3, 1, 0, 0, 2, 2, 4, 4, 6, 6, 6};

    int   tests_run;
    int   tests_failed;
    exp_t sb [$];
    bit   acc;
    bit   cons;

    function automatic longint sgn(input longint v);
        return (v < 0) ? -1 : ((v > 0) ? 1 : 0);
    endfunction

    function automatic exp_t model(input int res, input int sf);
        exp_t   e;
        longint n;
        int     sfv;
        int     mag;
        real    mult;
        n = (longint'(res) * longint'(RECIP[sf]) + 32768) >>> 16;
        n = n + sgn(longint'(res)) - sgn(n);
        if (n > 8)  n = 8;
        if (n < -8) n = -8;
        e.qr = QTAB[int'(n) + 8];
        sfv = int'($pow(real'(sf + 1), 2.75));
        case (e.qr / 2)
            0:       mult = 0.75;
            1:       mult = 2.5;
            2:       mult = 4.5;
            default: mult = 7.0;
        endcase
        mag     = int'(real'(sfv) * mult);
        e.recon = (e.qr % 2 == 1) ? -mag : mag;
        e.err   = res - e.recon;
        return e;
    endfunction

    function automatic int rand_residual();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return -65536;
            1:       return 65535;
            2:       return 0;
            3, 4, 5: return int'($urandom_range(0, 128)) - 64;
            default: return int'($urandom_range(0, 131071)) - 65536;
        endcase
    endfunction

    // Drive one cycle's inputs at the falling edge, then note what the next
    // rising edge will accept and consume. Accepted pairs enter the model queue.
    task automatic cyc(input bit v, input int res, input int sf, input bit ordy);
        @(negedge clk);
        in_valid  = v;
        residual  = 17'(res);
        sf_quant  = 4'(sf);
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        cons = out_valid & out_ready;
        if (acc)
            sb.push_back(model(res, sf));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; residual = '0; sf_quant = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || qr !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state got ov=%b ir=%b qr=%0d exp ov=0 ir=1 qr=0", out_valid, in_ready, qr);
        end
`ifdef QOA_QUANT_RECON_EN
        tests_run++;
        if (recon !== 16'sd0 || error !== 17'sd0) begin
            tests_failed++;
            $display("FAIL reset_recon got recon=%0d err=%0d exp 0 0", recon, error);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        localparam int N = 7;
        int d_res [N] = '{5, -3, 0, 100, -65536, 65535, 0};
        int d_sf  [N] = '{0, 0, 1, 1, 15, 15, 15};
        int d_qr  [N] = '{4, 3, 0, 6, 7, 6, 0};
        int d_rec [N] = '{5, -3, 5, 49, -14336, 14336, 1536};
        int k;
        exp_t e;
        // Latency: accepted at the first edge, visible after the second.
        cyc(1'b1, 5, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early got ov=%b exp 0", out_valid);
        end
        cyc(1'b0, 0, 0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_two got ov=%b exp 1", out_valid);
        end
        sb.delete();
        repeat (2) cyc(1'b0, 0, 0, 1'b1);
        k = 0;
        for (int c = 0; c < N + 6; c++) begin
            if (c < N) cyc(1'b1, d_res[c], d_sf[c], 1'b1);
            else       cyc(1'b0, 0, 0, 1'b1);
            if (cons) begin
                if (sb.size() != 0) e = sb.pop_front();
                tests_run++;
                if (k >= N || int'(qr) !== d_qr[k]) begin
                    tests_failed++;
                    $display("FAIL directed_qr[%0d] got %0d exp %0d", k, qr, (k < N) ? d_qr[k] : -1);
                end
`ifdef QOA_QUANT_RECON_EN
                tests_run++;
                if (k >= N || int'(recon) !== d_rec[k] || int'(error) !== d_res[k] - d_rec[k]) begin
                    tests_failed++;
                    $display("FAIL directed_recon[%0d] got recon=%0d err=%0d exp recon=%0d", k, recon, error,
                             (k < N) ? d_rec[k] : -1);
                end
`endif
                k++;
            end
        end
        tests_run++;
        if (k != N) begin
            tests_failed++;
            $display("FAIL directed_count got %0d exp %0d", k, N);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] held;
        int got;
        int c_res;
        int c_sf;
        sb.delete();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) cyc(1'b1, rand_residual(), int'($urandom_range(0, 15)), 1'b1);
            else       cyc(1'b0, 0, 0, 1'b1);
            tests_run++;
            if (cons !== (c >= 2 && c <= 9)) begin
                tests_failed++;
                $display("FAIL b2b_cadence[%0d] got cons=%b exp %b", c, cons, (c >= 2 && c <= 9));
            end
            if (cons && sb.size() != 0) begin
                e = sb.pop_front();
                tests_run++;
                if (int'(qr) !== e.qr) begin
                    tests_failed++;
                    $display("FAIL b2b_qr[%0d] got %0d exp %0d", c, qr, e.qr);
                end
            end
        end
        // Fill the pipe with the consumer stalled.
        cyc(1'b1, rand_residual(), int'($urandom_range(0, 15)), 1'b0);
        cyc(1'b1, rand_residual(), int'($urandom_range(0, 15)), 1'b0);
        c_res = rand_residual();
        c_sf  = int'($urandom_range(0, 15));
        held  = 3'd0;
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, c_res, c_sf, 1'b0);
            if (j == 0) held = qr;
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || qr !== held || acc) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d] got ir=%b ov=%b qr=%0d exp ir=0 ov=1 qr=%0d", j, in_ready, out_valid, qr, held);
            end
        end
        tests_run++;
        if (sb.size() == 0 || int'(held) !== sb[0].qr) begin
            tests_failed++;
            $display("FAIL stall_value got %0d exp %0d", held, (sb.size() != 0) ? sb[0].qr : -1);
        end
        cyc(1'b1, c_res, c_sf, 1'b1);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (cons) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL resume_extra got qr=%0d exp none", qr);
                end else begin
                    e = sb.pop_front();
                    if (int'(qr) !== e.qr) begin
                        tests_failed++;
                        $display("FAIL resume_qr got %0d exp %0d", qr, e.qr);
                    end
                end
                got++;
            end
            cyc(1'b0, 0, 0, 1'b1);
        end
        tests_run++;
        if (got != 3 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL resume_count got %0d left %0d exp 3 left 0", got, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        int got;
        sb.delete();
        cyc(1'b1, 1000, 2, 1'b1);
        cyc(1'b1, -1000, 3, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        // Between edges: first result visible, second in stage 1.
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || qr !== 3'd0) begin
            tests_failed++;
            $display("FAIL async_reset got ov=%b ir=%b qr=%0d exp ov=0 ir=1 qr=0", out_valid, in_ready, qr);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 0, 0, 1'b1);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_after_reset[%0d] got ov=%b exp 0", c, out_valid);
            end
        end
        cyc(1'b1, 100, 1, 1'b1);
        got = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 0, 0, 1'b1);
            if (cons) begin
                tests_run++;
                if (c != 1 || int'(qr) !== 6) begin
                    tests_failed++;
                    $display("FAIL post_reset_first got qr=%0d at %0d exp qr=6 at 1", qr, c);
                end
                got++;
            end
        end
        tests_run++;
        if (got != 1) begin
            tests_failed++;
            $display("FAIL post_reset_count got %0d exp 1", got);
        end
        sb.delete();
    endtask

    task automatic test_random();
        exp_t e;
        int got;
        int drain;
        sb.delete();
        got = 0;
        for (int c = 0; c < 600; c++) begin
            cyc($urandom_range(0, 9) < 7, rand_residual(), int'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0);
            if (cons) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra got qr=%0d exp none", qr);
                end else begin
                    e = sb.pop_front();
                    if (int'(qr) !== e.qr) begin
                        tests_failed++;
                        $display("FAIL rand_qr got %0d exp %0d", qr, e.qr);
                    end
`ifdef QOA_QUANT_RECON_EN
                    else if (int'(recon) !== e.recon || int'(error) !== e.err) begin
                        tests_failed++;
                        $display("FAIL rand_recon got recon=%0d err=%0d exp recon=%0d err=%0d",
                                 recon, error, e.recon, e.err);
                    end
`endif
                end
                got++;
            end
        end
        drain = 0;
        while (sb.size() != 0 && drain < 10) begin
            cyc(1'b0, 0, 0, 1'b1);
            if (cons) begin
                e = sb.pop_front();
                tests_run++;
                if (int'(qr) !== e.qr) begin
                    tests_failed++;
                    $display("FAIL drain_qr got %0d exp %0d", qr, e.qr);
                end
            end
            drain++;
        end
        tests_run++;
        if (sb.size() != 0 || got < 100) begin
            tests_failed++;
            $display("FAIL rand_drain got left=%0d results=%0d exp left=0", sb.size(), got);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        acc          = 1'b0;
        cons         = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
